// File: rtl/rt_mem_readback.sv
// Port-B read master: streams num_words_i consecutive words from RAM port B as {addr,data} on valid/ready.
// Optional running checksum output csum_o when RT_READBACK_CSUM_EN is defined.
module rt_mem_readback #(
    parameter int RAM_ADDR_WIDTH = 22,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_WORDS      = 4088,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [12:0]               num_words_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      en_b_o,
    output logic                      we_b_o,
    output logic [DATA_WIDTH/8-1:0]   be_b_o,
    output logic [RAM_ADDR_WIDTH-1:0] addr_b_o,
    input  logic [DATA_WIDTH-1:0]     rdata_b_i,
    input  logic                      rvalid_b_i,
    output logic                      word_valid_o,
    input  logic                      word_ready_i,
    output logic [DATA_WIDTH-1:0]     word_data_o,
    output logic [RAM_ADDR_WIDTH-1:0] word_addr_o,
`ifdef RT_READBACK_CSUM_EN
    output logic [DATA_WIDTH-1:0]     csum_o,
`endif
    output logic [2:0]                dbg_state
);
    // word_valid_o/word_ready_i: a word transfers on any cycle where both are high;
    // word_valid_o never drops and word_data_o/word_addr_o never change until then.

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [12:0]   MAX_CNT    = 13'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [12:0]               cnt;
    logic [TW-1:0]             timer;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [RAM_ADDR_WIDTH-1:0] data_addr_q;
    logic                      error_q;
    logic                      bad_len;
    logic                      timed_out;

    assign bad_len   = (num_words_i > MAX_CNT);
    assign timed_out = (timer == TIMER_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        en_b_o       = 1'b0;
        word_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    if (num_words_i == 13'd0 || bad_len) state_next = S_FIN;
                    else                                 state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_b_o     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rvalid_b_i)     state_next = S_OUT;
                else if (timed_out) state_next = S_FIN;
            end
            S_OUT: begin
                word_valid_o = 1'b1;
                if (word_ready_i) state_next = (cnt == 13'd1) ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef RT_READBACK_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    assign csum_o = csum_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr        <= '0;
            cnt         <= '0;
            timer       <= '0;
            data_q      <= '0;
            data_addr_q <= '0;
            error_q     <= 1'b0;
`ifdef RT_READBACK_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        addr    <= {base_addr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
                        cnt     <= num_words_i;
                        error_q <= bad_len;
`ifdef RT_READBACK_CSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    // Read data wins over a timeout landing on the same cycle.
                    if (rvalid_b_i) begin
                        data_q      <= rdata_b_i;
                        data_addr_q <= addr;
                    end else if (timed_out) begin
                        error_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OUT: begin
                    if (word_ready_i) begin
                        addr <= addr + RAM_ADDR_WIDTH'(4);
                        cnt  <= cnt - 13'd1;
`ifdef RT_READBACK_CSUM_EN
                        csum_q <= csum_q + data_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign error_o     = error_q;
    assign we_b_o      = 1'b0;
    assign be_b_o      = '1;
    assign addr_b_o    = addr;
    assign word_data_o = data_q;
    assign word_addr_o = data_addr_q;
    assign dbg_state   = state;

endmodule
